// File: rtl/mux4_rr_select.sv
// Round-robin select generator for a four-input mux. It grants one requester
// at a time and rotates fairly once the holder finishes, drops out or times out.
module mux4_rr_select #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       select1,
  output logic       select2,
  output logic [3:0] grant,
  output logic       valid,
  output logic       expired
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]    state_q,    state_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]    last_q,     last_d;
  logic [1:0]    sel_q,      sel_d;
  logic [3:0]    grant_q,    grant_d;
  logic          valid_q,    valid_d;
  logic          expired_q,  expired_d;

  logic       pick_found_s;
  logic [1:0] pick_idx_s;
  logic       rel_done_s;
  logic       rel_drop_s;
  logic       rel_lim_s;

  // First set request bit after the last grantee, wrapping so the last grantee comes last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int off = 4; off >= 1; off--) begin
      idx = last + 2'(off);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration search and release-cause decode.
  always_comb begin
    {pick_found_s, pick_idx_s} = rr_pick(req, last_q);
    rel_done_s = done;
    rel_drop_s = ~req[sel_q];
    rel_lim_s  = (hold_cnt_q == HOLD_LAST);
  end

  // Next-state logic for the IDLE/GRANT controller and all registered outputs.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    valid_d    = valid_q;
    expired_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d    = ST_GRANT;
          sel_d      = pick_idx_s;
          grant_d    = 4'b0001 << pick_idx_s;
          valid_d    = 1'b1;
          last_d     = pick_idx_s;
          hold_cnt_d = '0;
        end else begin
          grant_d = 4'b0000;
          valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        hold_cnt_d = hold_cnt_q + CW'(1);
        if (rel_done_s || rel_drop_s || rel_lim_s) begin
          state_d   = ST_IDLE;
          grant_d   = 4'b0000;
          valid_d   = 1'b0;
          // Timeout is only reported when nothing else ended the grant.
          expired_d = rel_lim_s & ~rel_done_s & ~rel_drop_s;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
        grant_d    = 4'b0000;
        valid_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves the pointer at 3 so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      last_q     <= 2'd3;
      sel_q      <= 2'd0;
      grant_q    <= 4'b0000;
      valid_q    <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      expired_q  <= expired_d;
    end
  end

  assign select1 = sel_q[0];
  assign select2 = sel_q[1];
  assign grant   = grant_q;
  assign valid   = valid_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_mux4_rr_select.sv
// Directed bench for mux4_rr_select with HOLD_MAX=8; outputs are checked 1 ns
// after each rising edge as {expired, valid, grant, select2, select1}.
module tb_mux4_rr_select;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       select1;
  logic       select2;
  logic [3:0] grant;
  logic       valid;
  logic       expired;

  int n_cmp;
  int n_err;

  logic [7:0] obs;
  assign obs = {expired, valid, grant, select2, select1};

  mux4_rr_select #(.HOLD_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .select1(select1), .select2(select2), .grant(grant),
    .valid(valid), .expired(expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Expected vector for an active grant on channel ch.
  function automatic logic [7:0] g_exp(input int ch);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    return {1'b0, 1'b1, oh, 2'(ch)};
  endfunction

  // Expected vector while idle with select held at ch.
  function automatic logic [7:0] i_exp(input int ch, input logic exp_pulse);
    return {exp_pulse, 1'b0, 4'b0000, 2'(ch)};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #12;
    chk("reset", 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("idle_%0d", i), 8'h00);
    end

    // Full contention: 0,1,2,3,0, eight cycles each, then one expired gap cycle.
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        chk($sformatf("rr_g%0d_c%0d", g, c), g_exp(g % 4));
      end
      step();
      chk($sformatf("rr_gap%0d", g), i_exp(g % 4, 1'b1));
    end

    // Mid-grant asynchronous reset.
    step();
    chk("pre_rst_grant1", g_exp(1));
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 8'h00);
    #1 rst_n = 1'b1;
    req = 4'b0100;

    // Single requester, done during the third grant cycle, then re-grant.
    step();
    chk("ch2_c0", g_exp(2));
    step();
    chk("ch2_c1", g_exp(2));
    step();
    chk("ch2_c2", g_exp(2));
    done = 1'b1;
    step();
    chk("ch2_done_rel", i_exp(2, 1'b0));
    done = 1'b0;
    step();
    chk("ch2_regrant", g_exp(2));

    // Release ch2, grant ch1, then its request drops in favour of ch3.
    done = 1'b1;
    req  = 4'b0010;
    step();
    chk("ch2_rel2", i_exp(2, 1'b0));
    done = 1'b0;
    step();
    chk("ch1_grant", g_exp(1));
    req = 4'b1000;
    step();
    chk("ch1_drop_rel", i_exp(1, 1'b0));
    step();
    chk("ch3_grant", g_exp(3));

    // Pointer wrap: after ch3, req=1001 must go to ch0, then back to ch3.
    req  = 4'b1001;
    done = 1'b1;
    step();
    chk("ch3_rel", i_exp(3, 1'b0));
    done = 1'b0;
    step();
    chk("wrap_ch0", g_exp(0));
    done = 1'b1;
    step();
    chk("ch0_rel", i_exp(0, 1'b0));
    done = 1'b0;
    step();
    chk("wrap_ch3", g_exp(3));

    // done coinciding with the hold limit: one release, no expired pulse.
    for (int c = 1; c < 8; c++) begin
      step();
      chk($sformatf("lim_c%0d", c), g_exp(3));
    end
    done = 1'b1;
    step();
    chk("lim_done_rel", i_exp(3, 1'b0));
    done = 1'b0;
    step();
    chk("after_lim_ch0", g_exp(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
